// File: rtl/jtframe_dual_ram_clr.sv
// True dual-port single-clock RAM with byte enables, 1/2-cycle read latency,
// selectable read-during-write behaviour and a self-timed clear sequencer.
module jtframe_dual_ram_clr #(
    parameter int             DW      = 16,
    parameter int             AW      = 10,
    parameter int             LATENCY = 1,
    parameter int             RDW     = 0,
    parameter logic [DW-1:0]  CLR_VAL = '0,
    parameter int             CLR_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    input  logic              cen0,
    input  logic [AW-1:0]     addr0,
    input  logic [DW-1:0]     data0,
    input  logic [DW/8-1:0]   we0,
    output logic [DW-1:0]     q0,
    input  logic              cen1,
    input  logic [AW-1:0]     addr1,
    input  logic [DW-1:0]     data1,
    input  logic [DW/8-1:0]   we1,
    output logic [DW-1:0]     q1
);
    localparam int BYTES = DW / 8;
    localparam int DEPTH = 2 ** AW;

    generate
        if ((DW % 8) != 0 || DW <= 0) begin : g_bad_dw
            $error("jtframe_dual_ram_clr: DW must be a positive multiple of 8");
        end
        if (LATENCY != 1 && LATENCY != 2) begin : g_bad_lat
            $error("jtframe_dual_ram_clr: LATENCY must be 1 or 2");
        end
    endgenerate

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   cnt_reg, cnt_next;
    logic            rst_d_reg;
    logic            busy_int;

    logic [DW-1:0]   mem [DEPTH];

    logic [1:0]      cen_v;
    logic [1:0]      wr_v;
    logic [AW-1:0]   addr_v [2];
    logic [DW-1:0]   data_v [2];
    logic [BYTES-1:0] we_v  [2];
    logic [DW-1:0]   q_v    [2];

    assign cen_v     = {cen1, cen0};
    assign addr_v[0] = addr0;
    assign addr_v[1] = addr1;
    assign data_v[0] = data0;
    assign data_v[1] = data1;
    assign we_v[0]   = we0;
    assign we_v[1]   = we1;
    assign q0        = q_v[0];
    assign q1        = q_v[1];

    assign busy_int = (state_reg == CLEAR);
    assign busy     = busy_int;
    // User writes are dropped during the clear so the sequencer owns the array.
    assign wr_v     = cen_v & {2{~busy_int & ~rst}};

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (clr || (CLR_RST != 0 && rst_d_reg))
                    state_next = CLEAR;
            end
            CLEAR: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == {AW{1'b1}})
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rst_d_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rst_d_reg <= 1'b0;
        end
    end

    // Port 1 is applied last so it wins on bytes both ports enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy_int) begin
                mem[cnt_reg] <= CLR_VAL;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (wr_v[p] && we_v[p][b])
                            mem[addr_v[p]][8*b +: 8] <= data_v[p][8*b +: 8];
                    end
                end
            end
        end
    end

    genvar gi, gb;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DW-1:0] rd_word;
            logic [DW-1:0] q_reg;
            logic          rd_en;

            assign rd_en    = cen_v[gi] & ~busy_int;
            assign q_v[gi]  = q_reg;

            // New-data mode bypasses this cycle's writes from either port.
            for (gb = 0; gb < BYTES; gb++) begin : g_byte
                assign rd_word[gb*8 +: 8] =
                    (RDW != 0 && wr_v[1] && addr_v[1] == addr_v[gi] && we_v[1][gb]) ? data_v[1][gb*8 +: 8] :
                    (RDW != 0 && wr_v[0] && addr_v[0] == addr_v[gi] && we_v[0][gb]) ? data_v[0][gb*8 +: 8] :
                    mem[addr_v[gi]][gb*8 +: 8];
            end

            if (LATENCY == 2) begin : g_lat2
                logic [DW-1:0] p_reg;
                always_ff @(posedge clk) begin
                    if (rst) begin
                        p_reg <= '0;
                        q_reg <= '0;
                    end else if (rd_en) begin
                        p_reg <= rd_word;
                        q_reg <= p_reg;
                    end
                end
            end else begin : g_lat1
                always_ff @(posedge clk) begin
                    if (rst)
                        q_reg <= '0;
                    else if (rd_en)
                        q_reg <= rd_word;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_jtframe_dual_ram_clr.sv
// Scoreboard bench: two RAM instances (old-data/latency-1 and new-data/latency-2)
// share stimulus; a word-level memory model predicts every read and busy.
module tb_jtframe_dual_ram_clr;
    localparam int          DW    = 16;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [15:0] CLRV  = 16'hC1A5;

    logic        clk = 1'b0;
    logic        rst, clr;
    logic        cen0, cen1;
    logic [3:0]  addr0, addr1;
    logic [15:0] data0, data1;
    logic [1:0]  we0, we1;
    logic        busy_a, busy_b;
    logic [15:0] qa0, qa1, qb0, qb1;

    always #5 clk = ~clk;

    jtframe_dual_ram_clr #(.DW(DW), .AW(AW), .LATENCY(1), .RDW(0), .CLR_VAL(CLRV), .CLR_RST(1)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_a),
        .cen0(cen0), .addr0(addr0), .data0(data0), .we0(we0), .q0(qa0),
        .cen1(cen1), .addr1(addr1), .data1(data1), .we1(we1), .q1(qa1));

    jtframe_dual_ram_clr #(.DW(DW), .AW(AW), .LATENCY(2), .RDW(1), .CLR_VAL(CLRV), .CLR_RST(1)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_b),
        .cen0(cen0), .addr0(addr0), .data0(data0), .we0(we0), .q0(qb0),
        .cen1(cen1), .addr1(addr1), .data1(data1), .we1(we1), .q1(qb1));

    typedef struct {
        logic [15:0] exp;
        int          due;
    } ent_t;

    // Queues 0/1: instance A port 0/1; queues 2/3: instance B port 0/1.
    ent_t        sb [4][$];
    logic [15:0] mem_m [DEPTH];
    int          clr_left = 0;
    logic        rst_prev = 1'b1;
    logic        exp_busy = 1'b0;
    int          en_cnt [2];
    int          vectors = 0;
    int          miscompares = 0;
    logic        mon_on = 1'b0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end else begin
            $display("ok   %s @%0t: %h", nm, $time, act);
        end
    endtask

    function automatic logic [15:0] act_q(input int i);
        case (i)
            0:       return qa0;
            1:       return qa1;
            2:       return qb0;
            default: return qb1;
        endcase
    endfunction

    // One clock cycle: drive inputs, advance the reference model, queue expected reads.
    task automatic step(input logic r, input logic c,
                        input logic e0, input logic [3:0] a0, input logic [15:0] d0, input logic [1:0] w0,
                        input logic e1, input logic [3:0] a1, input logic [15:0] d1, input logic [1:0] w1);
        logic [15:0] nm [DEPTH];
        logic        busy_now;
        logic        en [2];
        logic [3:0]  ad [2];
        ent_t        e;
        rst = r; clr = c;
        cen0 = e0; addr0 = a0; data0 = d0; we0 = w0;
        cen1 = e1; addr1 = a1; data1 = d1; we1 = w1;
        busy_now = (clr_left > 0);
        ad[0] = a0; ad[1] = a1;
        en[0] = e0 && !busy_now && !r;
        en[1] = e1 && !busy_now && !r;
        if (r) begin
            clr_left = 0;
            for (int i = 0; i < 4; i++) sb[i].delete();
        end else if (busy_now) begin
            mem_m[DEPTH - clr_left] = CLRV;
            clr_left--;
        end else begin
            nm = mem_m;
            for (int b = 0; b < 2; b++) begin
                if (en[0] && w0[b]) nm[a0][8*b +: 8] = d0[8*b +: 8];
            end
            for (int b = 0; b < 2; b++) begin
                if (en[1] && w1[b]) nm[a1][8*b +: 8] = d1[8*b +: 8];
            end
            for (int p = 0; p < 2; p++) begin
                if (en[p]) begin
                    e.exp = mem_m[ad[p]]; e.due = en_cnt[p] + 1; sb[p].push_back(e);
                    e.exp = nm[ad[p]];    e.due = en_cnt[p] + 2; sb[2+p].push_back(e);
                end
            end
            mem_m = nm;
            if (c || rst_prev) clr_left = DEPTH;
        end
        rst_prev = r;
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) if (en[p]) en_cnt[p]++;
        exp_busy = (clr_left > 0);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
        step(0, 0, 1, a0, 16'h0, 2'b00, 1, a1, 16'h0, 2'b00);
    endtask

    task automatic chk_q_zero(input string tag);
        check({tag, "_qa0"}, qa0, 16'h0);
        check({tag, "_qa1"}, qa1, 16'h0);
        check({tag, "_qb0"}, qb0, 16'h0);
        check({tag, "_qb1"}, qb1, 16'h0);
    endtask

    // Monitor: busy every cycle, and each queued read once its latency has elapsed.
    initial begin
        ent_t e;
        wait (mon_on);
        forever begin
            @(negedge clk);
            check("busy_a", {15'h0, busy_a}, {15'h0, exp_busy});
            check("busy_b", {15'h0, busy_b}, {15'h0, exp_busy});
            for (int i = 0; i < 4; i++) begin
                if (sb[i].size() > 0 && sb[i][0].due <= en_cnt[i % 2]) begin
                    e = sb[i].pop_front();
                    check($sformatf("q%0d_inst%s", i % 2, (i < 2) ? "A" : "B"), act_q(i), e.exp);
                end
            end
        end
    end

    initial begin
        logic [3:0] ra0, ra1;
        en_cnt[0] = 0; en_cnt[1] = 0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 'x;
        rst = 1; clr = 0; cen0 = 0; cen1 = 0; addr0 = 0; addr1 = 0;
        data0 = 0; data1 = 0; we0 = 0; we1 = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mon_on = 1'b1;
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_q_zero("reset");

        // Automatic clear after reset, then every location reads CLR_VAL.
        idle(DEPTH + 2);
        for (int a = 0; a < DEPTH; a++) rd(4'(a), 4'(DEPTH - 1 - a));

        // Byte-enable merge.
        step(0, 0, 1, 4'd5, 16'hABCD, 2'b11, 0, 0, 0, 0);
        step(0, 0, 1, 4'd5, 16'h1200, 2'b10, 0, 0, 0, 0);
        rd(5, 5);

        // Cross-port read during write.
        step(0, 0, 1, 4'd7, 16'h1111, 2'b11, 0, 0, 0, 0);
        step(0, 0, 1, 4'd7, 16'h2222, 2'b11, 1, 4'd7, 16'h0, 2'b00);
        rd(7, 7);

        // Simultaneous writes to one address.
        step(0, 0, 1, 4'd3, 16'hAAAA, 2'b11, 1, 4'd3, 16'h5555, 2'b01);
        rd(3, 3);
        rd(3, 3);

        // Random traffic with collisions, gaps in cen and occasional clears.
        for (int i = 0; i < 400; i++) begin
            ra0 = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            ra1 = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            step(0, ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 3) != 0), ra0, 16'($urandom), 2'($urandom),
                 ($urandom_range(0, 3) != 0), ra1, 16'($urandom), 2'($urandom));
        end
        idle(DEPTH + 2);

        // Clear on request over a full array; writes and clr during busy are ignored.
        for (int a = 0; a < DEPTH; a++) step(0, 0, 1, 4'(a), 16'hFFFF, 2'b11, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            step(0, (i == 5), 1, 4'd2, 16'h1234, 2'b11, 1, 4'(i), 16'h4321, 2'b11);
        idle(2);
        for (int a = 0; a < DEPTH; a++) rd(4'(a), 4'(a));

        // Reset in the middle of a clear, then a fresh clear from address 0.
        for (int a = 0; a < DEPTH; a++) step(0, 0, 1, 4'(a), 16'h0F0F, 2'b11, 0, 0, 0, 0);
        rd(9, 12);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(8);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_q_zero("midclr_rst");
        idle(DEPTH + 2);
        for (int a = 0; a < DEPTH; a++) rd(4'(a), 4'(DEPTH - 1 - a));
        idle(3);

        for (int i = 0; i < 4; i++) begin
            foreach (sb[i][k]) begin
                if (sb[i][k].due <= en_cnt[i % 2]) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_leftover q%0d: got none expected %h", i, sb[i][k].exp);
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
